// File: rtl/swerv_types.sv
// Shared types for the EXU iterative divider: issue packet, FSM encoding, iteration count.
package swerv_types;

    localparam int DIV_ITER = 32;

    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } div_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/exu_div_fix.sv
// FIX-stage datapath: restores a negative final remainder, applies operand signs
// and selects quotient or remainder. Fast-path results pass through untouched.
module exu_div_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] q,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic             fast,
    input  logic             rem_sel,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH-1:0] rem_mag, quo, rem;

    // True remainder lies in [0, m), so the low WIDTH bits of the sum are exact.
    assign rem_mag = r[WIDTH] ? (r[WIDTH-1:0] + m) : r[WIDTH-1:0];

    always_comb begin
        quo = q;
        rem = r[WIDTH-1:0];
        if (!fast) begin
            quo = neg_q ? -q : q;
            rem = neg_r ? -rem_mag : rem_mag;
        end
    end

    assign res = rem_sel ? rem : quo;

endmodule

// File: rtl/exu_div_iter.sv
// Iterative non-restoring radix-2 divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional RV_DIV_SMALL_SKIP_EN: |dividend| < |divisor| resolves on the fast path.
module exu_div_iter
    import swerv_types::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_mode,
    input  logic             clk_override,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  div_pkt_t         dp,
    input  logic             flush,
    output logic             div_busy,
    output logic             div_finish,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DIV_ITER - 1);

    div_state_t       state;
    logic             finish_q;

    logic [WIDTH-1:0] a_q, m_q;
    logic [WIDTH:0]   r_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q, neg_r, rem_sel, fast_q;

    logic             start, sgn, div_zero, ovf, small_skip, fast_path, en;
    logic [WIDTH-1:0] dd_mag, ds_mag, fix_res;
    logic [WIDTH:0]   r_sh, r_new;

    assign start    = dp.valid & ~flush & (state == IDLE);
    assign sgn      = ~dp.unsign;
    assign dd_mag   = (sgn & dividend[WIDTH-1]) ? -dividend : dividend;
    assign ds_mag   = (sgn & divisor[WIDTH-1])  ? -divisor  : divisor;
    assign div_zero = (divisor == '0);
    assign ovf      = sgn & (dividend == MIN_NEG) & (divisor == '1);
`ifdef RV_DIV_SMALL_SKIP_EN
    assign small_skip = ~div_zero & (dd_mag < ds_mag);
`else
    assign small_skip = 1'b0;
`endif
    assign fast_path = div_zero | ovf | small_skip;
    assign en        = (state != IDLE) | dp.valid | clk_override | scan_mode;

    // Decision uses the sign of the stored remainder; a wrap of r_sh is harmless
    // because the post-add/subtract value always fits in WIDTH+1 bits.
    assign r_sh  = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
    assign r_new = r_q[WIDTH] ? (r_sh + {1'b0, m_q}) : (r_sh - {1'b0, m_q});

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            a_q     <= '0;
            r_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
            fast_q  <= 1'b0;
        end else if (en) begin
            if (start) begin
                m_q     <= ds_mag;
                cnt_q   <= '0;
                rem_sel <= dp.rem;
                fast_q  <= fast_path;
                neg_q   <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r   <= sgn & dividend[WIDTH-1];
                if (div_zero) begin
                    a_q <= '1;
                    r_q <= {1'b0, dividend};
                end else if (ovf) begin
                    a_q <= MIN_NEG;
                    r_q <= '0;
                end else if (small_skip) begin
                    a_q <= '0;
                    r_q <= {1'b0, dividend};
                end else begin
                    a_q <= dd_mag;
                    r_q <= '0;
                end
            end else if (state == RUN) begin
                a_q   <= {a_q[WIDTH-2:0], ~r_new[WIDTH]};
                r_q   <= r_new;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    exu_div_fix #(.WIDTH(WIDTH)) u_fix (
        .r       (r_q),
        .m       (m_q),
        .q       (a_q),
        .neg_q   (neg_q),
        .neg_r   (neg_r),
        .fast    (fast_q),
        .rem_sel (rem_sel),
        .res     (fix_res)
    );

    // Fast results still pass through FIX so finish lands two cycles after issue.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= IDLE;
            div_busy <= 1'b0;
            finish_q <= 1'b0;
            out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= fast_path ? FIX : RUN;
                        div_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state    <= IDLE;
                        div_busy <= 1'b0;
                    end else if (cnt_q == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state    <= IDLE;
                        div_busy <= 1'b0;
                    end else begin
                        state    <= DONE;
                        finish_q <= 1'b1;
                        out      <= fix_res;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    div_busy <= 1'b0;
                    finish_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    div_busy <= 1'b0;
                    finish_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_finish = finish_q & ~flush;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_l) begin
            assert (!(dp.valid && div_busy))
                else $error("exu_div_iter: dp.valid issued while div_busy");
        end
    end
`endif

endmodule

// File: tb/tb_exu_div_iter.sv
// Directed bench for exu_div_iter: hand-computed quotients/remainders, latency, flush, reset.
module tb_exu_div_iter;
    import swerv_types::*;

    logic        clk = 1'b0;
    logic        rst_l, scan_mode, clk_override, flush;
    logic [31:0] dividend, divisor, out;
    div_pkt_t    dp;
    logic        div_busy, div_finish;

    int n_cmp = 0;
    int n_err = 0;

`ifdef RV_DIV_SMALL_SKIP_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = 34;
`endif

    exu_div_iter dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .scan_mode    (scan_mode),
        .clk_override (clk_override),
        .dividend     (dividend),
        .divisor      (divisor),
        .dp           (dp),
        .flush        (flush),
        .div_busy     (div_busy),
        .div_finish   (div_finish),
        .out          (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge in an IDLE cycle; that cycle is T.
    task automatic run_op(input string tag, input logic [31:0] dd, input logic [31:0] ds,
                          input logic u, input logic rm, input logic [31:0] exp, input int exp_lat);
        int lat;
        dividend = dd;
        divisor  = ds;
        dp       = '{valid: 1'b1, unsign: u, rem: rm};
        @(negedge clk);
        dp.valid = 1'b0;
        lat = 1;
        chk({tag, "_busy_t1"}, 32'(div_busy), 32'd1);
        while (!div_finish && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out"}, out, exp);
        chk({tag, "_busy_fin"}, 32'(div_busy), 32'd1);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(div_busy), 32'd0);
        chk({tag, "_fin_after"}, 32'(div_finish), 32'd0);
    endtask

    initial begin
        int nfin;
        rst_l = 1'b0; scan_mode = 1'b0; clk_override = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0; dp = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_fin", 32'(div_finish), 32'd0);
        chk("rst_out", out, 32'd0);
        rst_l = 1'b1;
        @(negedge clk);

        run_op("div_100_7",   32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34);
        run_op("rem_100_7",   32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34);
        run_op("div_m100_7",  -32'sd100, 32'd7, 1'b0, 1'b0, 32'hFFFF_FFF2, 34);
        run_op("rem_m100_7",  -32'sd100, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 34);
        run_op("div_7_m2",    32'd7, -32'sd2, 1'b0, 1'b0, 32'hFFFF_FFFD, 34);
        run_op("rem_7_m2",    32'd7, -32'sd2, 1'b0, 1'b1, 32'd1, 34);
        run_op("divu_max_2",  32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 32'h7FFF_FFFF, 34);
        run_op("divu_min_3",  32'h8000_0000, 32'd3, 1'b1, 1'b0, 32'h2AAA_AAAA, 34);
        run_op("remu_min_3",  32'h8000_0000, 32'd3, 1'b1, 1'b1, 32'd2, 34);
        run_op("divu_bigds",  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd1, 34);
        run_op("remu_bigds",  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, 34);
        run_op("divu_5_0",    32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 2);
        run_op("remu_5_0",    32'd5, 32'd0, 1'b1, 1'b1, 32'd5, 2);
        run_op("div_ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 2);
        run_op("rem_ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 2);
        run_op("div_3_10",    32'd3, 32'd10, 1'b0, 1'b0, 32'd0, SMALL_LAT);
        run_op("rem_3_10",    32'd3, 32'd10, 1'b0, 1'b1, 32'd3, SMALL_LAT);

        // Flush in cycle T+10 of a normal divide, then reissue at T+11.
        dividend = 32'd100; divisor = 32'd7;
        dp = '{valid: 1'b1, unsign: 1'b0, rem: 1'b0};
        nfin = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            dp.valid = 1'b0;
            if (div_finish) nfin++;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        chk("flush_no_fin", 32'(nfin), 32'd0);
        chk("flush_busy", 32'(div_busy), 32'd0);
        run_op("div_9_3", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 34);

        // Asynchronous reset in the middle of a divide.
        dividend = 32'd100; divisor = 32'd7;
        dp = '{valid: 1'b1, unsign: 1'b0, rem: 1'b0};
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            dp.valid = 1'b0;
        end
        rst_l = 1'b0;
        #1;
        chk("mrst_busy", 32'(div_busy), 32'd0);
        chk("mrst_fin", 32'(div_finish), 32'd0);
        chk("mrst_out", out, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        nfin = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_finish || div_busy) nfin++;
        end
        chk("mrst_no_fin", 32'(nfin), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
